// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - memory-stage to writeback-stage pass-through bundle
interface mem_wb_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ValidM;
  logic                  RegWriteM;
  logic [1:0]            ResultSrcM;
  logic [DATA_WIDTH-1:0] ReadDataM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] PCPlus4M;
  logic [4:0]            RdM;

  modport master (
    output ValidM, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, PCPlus4M, RdM
  );

  modport slave (
    input ValidM, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, PCPlus4M, RdM
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, writeback mux and retire counter
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  mem_wb_stage_if.slave         m,
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [CNT_WIDTH-1:0]  InstRetW
);

  localparam logic [1:0]           SRC_ALU  = 2'b00;
  localparam logic [1:0]           SRC_MEM  = 2'b01;
  localparam logic [1:0]           SRC_PC4  = 2'b10;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            resultsrc_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic [DATA_WIDTH-1:0] aluresult_q;
  logic [DATA_WIDTH-1:0] pcplus4_q;

  // The instruction in WB leaves whenever the slot is not held; a flush
  // overrides a stall, so the departing instruction still retires then.
  logic retire;
  assign retire = ValidW & (~StallW | FlushW);

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      RdW         <= 5'd0;
      resultsrc_q <= 2'b00;
      readdata_q  <= '0;
      aluresult_q <= '0;
      pcplus4_q   <= '0;
      InstRetW    <= '0;
    end else begin
      if (retire) begin
        InstRetW <= InstRetW + CNT_ONE;
      end

      if (FlushW) begin
        ValidW      <= 1'b0;
        RegWriteW   <= 1'b0;
        RdW         <= 5'd0;
        resultsrc_q <= 2'b00;
        readdata_q  <= '0;
        aluresult_q <= '0;
        pcplus4_q   <= '0;
      end else if (!StallW) begin
        ValidW      <= m.ValidM;
        // Bubbles and x0 destinations never raise the register-file write.
        RegWriteW   <= m.RegWriteM & m.ValidM & (m.RdM != 5'd0);
        RdW         <= m.RdM;
        resultsrc_q <= m.ResultSrcM;
        readdata_q  <= m.ReadDataM;
        aluresult_q <= m.ALUResultM;
        pcplus4_q   <= m.PCPlus4M;
      end
    end
  end

  // Load data arrives already extended, so the mux is a plain select.
  always_comb begin
    ResultW = '0;
    case (resultsrc_q)
      SRC_ALU: ResultW = aluresult_q;
      SRC_MEM: ResultW = readdata_q;
      SRC_PC4: ResultW = pcplus4_q;
      default: ResultW = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized model-checked bench for mem_wb_stage
module tb_mem_wb_stage;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          StallW;
  logic          FlushW;
  logic          ValidW, RegWriteW;
  logic [4:0]    RdW;
  logic [DW-1:0] ResultW;
  logic [63:0]   InstRetW;
  logic          sValidW, sRegWriteW;
  logic [4:0]    sRdW;
  logic [DW-1:0] sResultW;
  logic [3:0]    sInstRetW;

  mem_wb_stage_if #(.DATA_WIDTH(DW)) mif ();

  mem_wb_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .m(mif.slave),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .InstRetW(InstRetW)
  );

  mem_wb_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .m(mif.slave),
    .ValidW(sValidW), .RegWriteW(sRegWriteW), .RdW(sRdW), .ResultW(sResultW),
    .InstRetW(sInstRetW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference: what the WB slot holds, with the writeback value resolved
  // at capture time, plus an unbounded retire count.
  bit            m_valid;
  bit            m_rw;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_res;
  logic [63:0]   m_cnt;

  function automatic logic [DW-1:0] pick(input logic [1:0] src, input logic [DW-1:0] alu,
                                         input logic [DW-1:0] mem, input logic [DW-1:0] pc4);
    if (src == 2'd0) return alu;
    if (src == 2'd1) return mem;
    if (src == 2'd2) return pc4;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    end else begin
      if (m_valid && (!StallW || FlushW)) m_cnt = m_cnt + 64'd1;
      if (FlushW) begin
        m_valid = 0; m_rw = 0; m_rd = 0; m_res = 0;
      end else if (!StallW) begin
        m_valid = mif.ValidM;
        m_rw    = mif.ValidM && mif.RegWriteM && (mif.RdM != 0);
        m_rd    = mif.RdM;
        m_res   = pick(mif.ResultSrcM, mif.ALUResultM, mif.ReadDataM, mif.PCPlus4M);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ValidW",     {63'd0, ValidW},    {63'd0, m_valid});
      check("RegWriteW",  {63'd0, RegWriteW}, {63'd0, m_rw});
      check("RdW",        {59'd0, RdW},       {59'd0, m_rd});
      check("ResultW",    {32'd0, ResultW},   {32'd0, m_res});
      check("InstRetW",   InstRetW,           m_cnt);
      check("InstRetW4",  {60'd0, sInstRetW}, {60'd0, m_cnt[3:0]});
      check("RegWriteW4", {63'd0, sRegWriteW}, {63'd0, m_rw});
    end
  end

  task automatic set_m(input bit v, input bit rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] pc4);
    mif.ValidM = v; mif.RegWriteM = rw; mif.ResultSrcM = src; mif.RdM = rd;
    mif.ALUResultM = alu; mif.ReadDataM = mem; mif.PCPlus4M = pc4;
  endtask

  task automatic rand_m();
    set_m(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1; StallW = 0; FlushW = 0;
    rand_m();
    chk_en = 1;
    cyc();
    rand_m(); StallW = 1; FlushW = 1;
    cyc();
    check("rst ValidW",   {63'd0, ValidW},    64'd0);
    check("rst RegWrite", {63'd0, RegWriteW}, 64'd0);
    check("rst RdW",      {59'd0, RdW},       64'd0);
    check("rst ResultW",  {32'd0, ResultW},   64'd0);
    check("rst InstRetW", InstRetW,           64'd0);

    rst = 0; StallW = 0; FlushW = 0;
    for (int s = 0; s < 4; s++) begin
      set_m(1, 1, 2'(s), 5'd5, 32'h10, 32'hDEADBEEF, 32'h104);
      cyc();
      check("sel RdW", {59'd0, RdW}, 64'd5);
      check("sel RegWriteW", {63'd0, RegWriteW}, 64'd1);
      check("sel InstRetW", InstRetW, 64'(s));
      case (s)
        0: check("sel alu", {32'd0, ResultW}, 64'h10);
        1: check("sel mem", {32'd0, ResultW}, 64'hDEADBEEF);
        2: check("sel pc4", {32'd0, ResultW}, 64'h104);
        default: check("sel rsv", {32'd0, ResultW}, 64'h0);
      endcase
    end

    set_m(1, 1, 2'd0, 5'd0, 32'h55, 32'h0, 32'h0);
    cyc();
    check("x0 RegWriteW", {63'd0, RegWriteW}, 64'd0);
    check("x0 RdW", {59'd0, RdW}, 64'd0);
    check("x0 ValidW", {63'd0, ValidW}, 64'd1);
    check("x0 InstRetW", InstRetW, 64'd4);
    set_m(0, 1, 2'd0, 5'd4, 32'h1, 32'h2, 32'h3);
    cyc();
    check("bubble RegWriteW", {63'd0, RegWriteW}, 64'd0);
    check("x0 retired", InstRetW, 64'd5);

    set_m(1, 1, 2'd0, 5'd7, 32'h7, 32'h0, 32'h0);
    cyc();
    check("stall pre RdW", {59'd0, RdW}, 64'd7);
    check("bubble not counted", InstRetW, 64'd5);
    StallW = 1;
    set_m(1, 1, 2'd0, 5'd9, 32'h9, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall RdW", {59'd0, RdW}, 64'd7);
      check("stall ResultW", {32'd0, ResultW}, 64'h7);
      check("stall InstRetW", InstRetW, 64'd5);
    end
    StallW = 0;
    cyc();
    check("release RdW", {59'd0, RdW}, 64'd9);
    check("release InstRetW", InstRetW, 64'd6);

    set_m(1, 1, 2'd0, 5'd3, 32'h33, 32'h0, 32'h0);
    cyc();
    check("flush pre RdW", {59'd0, RdW}, 64'd3);
    check("flush pre InstRetW", InstRetW, 64'd7);
    FlushW = 1; StallW = 1;
    cyc();
    check("flush ValidW", {63'd0, ValidW}, 64'd0);
    check("flush RegWriteW", {63'd0, RegWriteW}, 64'd0);
    check("flush RdW", {59'd0, RdW}, 64'd0);
    check("flush InstRetW", InstRetW, 64'd8);
    FlushW = 0; StallW = 0;
    set_m(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("post-flush bubble", InstRetW, 64'd8);

    rst = 1;
    cyc();
    rst = 0;
    set_m(1, 1, 2'd1, 5'd1, 32'h0, 32'h11, 32'h0);
    for (int i = 0; i < 16; i++) cyc();
    check("wrap at 15", {60'd0, sInstRetW}, 64'd15);
    set_m(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("wrap to 0", {60'd0, sInstRetW}, 64'd0);
    check("wide no wrap", InstRetW, 64'd16);

    for (int i = 0; i < 3000; i++) begin
      rand_m();
      rst    = ($urandom_range(0, 49) == 0);
      FlushW = ($urandom_range(0, 9) == 0);
      StallW = ($urandom_range(0, 4) == 0);
      cyc();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and writeback stage directly downstream of the memory stage.
- Captures the memory stage's pass-through outputs (RegWrite, ResultSrc, ReadData, Rd, PC+4, ALU result) each cycle and selects the writeback result.
- Drives register-file write and forwarding signals.
- Tracks instruction validity through stall/flush and counts retired instructions.

Parameters:
- DATA_WIDTH, 32, datapath width
- CNT_WIDTH, 64, retired-instruction counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- StallW  input  1  hold all WB state this cycle
- FlushW  input  1  load a bubble instead of the incoming instruction
- ValidM  input  1  memory-stage slot holds a real instruction
- RegWriteM  input  1  instruction writes rd
- ResultSrcM  input  2  00 ALU result, 01 read data, 10 PC+4, 11 reserved
- ReadDataM  input  DATA_WIDTH  load data from data memory
- ALUResultM  input  DATA_WIDTH  ALU result
- PCPlus4M  input  DATA_WIDTH  PC+4
- RdM  input  5  destination register
- ValidW  output  1  WB slot holds a real instruction
- RegWriteW  output  1  register-file write enable (qualified)
- RdW  output  5  register-file write address
- ResultW  output  DATA_WIDTH  register-file write data / forwarding value
- InstRetW  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: when rst=1 at a rising edge, all of the following clear to 0: ValidW, RegWriteW, RdW, the internal ResultSrc/ReadData/ALUResult/PCPlus4 registers, and InstRetW. ResultW therefore reads 0 after reset.
- Update priority per edge: rst > FlushW > StallW > normal load.
- Normal load (no rst/flush/stall):
  - All fields capture their M inputs.
  - ValidW <= ValidM.
  - RegWriteW <= RegWriteM & ValidM & (RdM != 0). Writes to x0 are never asserted.
- FlushW=1:
  - ValidW, RegWriteW and RdW clear to 0. Data registers and ResultSrc clear to 0.
  - FlushW overrides StallW in the same cycle.
- StallW=1 (no flush): every WB register holds its value.
- Latency: exactly 1 cycle from M inputs to W outputs.
- ResultW is combinational from the registered fields:
  - ResultSrc 00 -> ALUResult; 01 -> ReadData; 10 -> PCPlus4; 11 -> 0.
  - No sign or byte extension here; data memory already returns extended load data.
- Retire counter:
  - InstRetW increments by 1 on any edge where rst=0, ValidW=1 and StallW=0, i.e. the instruction currently in WB retires.
  - It increments even if FlushW=1 on that edge, because flush affects only the incoming slot.
  - Wraps from all-ones to 0 with no saturation.
- A bubble (ValidW=0) never counts and never asserts RegWriteW, regardless of the registered ResultSrc or data.
- Reset mid-stall or mid-flush: reset wins; all state is 0 on the next cycle.
- No combinational path from M inputs to any W output.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> ValidW=0, RegWriteW=0, RdW=0, ResultW=0, InstRetW=0.
- Result select: ValidM=1, RegWriteM=1, RdM=5, ALUResultM=0x10, ReadDataM=0xDEADBEEF, PCPlus4M=0x104, ResultSrcM stepped 00/01/10/11 on consecutive cycles -> one cycle later ResultW = 0x10, 0xDEADBEEF, 0x104, 0. RdW=5 and RegWriteW=1 throughout. InstRetW increments each cycle.
- x0 suppression: ValidM=1, RegWriteM=1, RdM=0, ALUResultM=0x55 -> RegWriteW=0, RdW=0, ValidW=1. InstRetW still increments after that instruction retires.
- Stall hold: load RdM=7, ALUResultM=0x7 -> then StallW=1 for 3 cycles while inputs change to RdM=9 -> RdW=7 and ResultW=0x7 held. InstRetW frozen during the stall. On release, RdW=9 next cycle.
- Flush vs stall: valid instruction (Rd=3) in WB, then FlushW=1 and StallW=1 on the same edge -> next cycle ValidW=0, RegWriteW=0, RdW=0. InstRetW incremented by 1 for the departing Rd=3 instruction. The following bubble cycle adds nothing.
- Counter wrap: force InstRetW to all-ones (CNT_WIDTH=4 build: 15), then retire one valid instruction -> InstRetW=0.
